bloco_controle_iter: RTL and testbench
======================================

// Module: bloco_controle_iter
// PURPOSE
//  Parametrised successor control FSM for the iterative datapath (X/H/S registers, three operand muxes).
//  Sequences one load step, N repetitions of a 4-step loop body, a 2-step epilogue, then raises pronto.
//  Adds a runtime iteration count, a done/ack handshake and an optional abort. Sits beside the datapath in the top level.
// PARAMETERS
//  CNT_W         4   width of n_iter and of the internal iteration counter
//  SEL_W         2   width of M0/M1/M2; must be >= 2; codes zero-extended
//  AUTO_RESTART  0   1: DONE returns to IDLE after one cycle without ack; 0: DONE holds until ack
// PORTS
//  clk      in   1      single clock, rising edge
//  rst_n    in   1      asynchronous reset, active-low
//  inicio   in   1      start request, sampled in IDLE only
//  n_iter   in   CNT_W  loop count, captured on the IDLE->LOAD edge
//  ack      in   1      consumer accepts result; consumed in DONE only
//  M0,M1,M2 out  SEL_W  datapath mux selects
//  LX,LH,LS out  1      load enables for X, H, S registers
//  H        out  1      H-path enable
//  pronto   out  1      result valid (DONE)
//  ocupado  out  1      1 in every state except IDLE and DONE
//  iter     out  CNT_W  current loop index (0-based), held at last value outside loop
//  abortar  in   1      only with BLOCO_CTRL_ABORT_EN
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, counter=0, n_reg=0; all outputs 0.
//  Outputs are Moore, decoded from state only (no input-to-output comb path).
//  State / outputs (unlisted = 0):
//   IDLE  : -                                  -> LOAD if inicio, else stay
//   LOAD  : LX=1 H=1 M1=1                      -> B_MUL if n_reg!=0, else E_POST
//   B_MUL : H=1 M1=1                           -> B_ACC
//   B_ACC : LH=1 H=1 M1=1                      -> B_SUM
//   B_SUM : LS=1 H=1 M0=1 M1=3 M2=1            -> B_UPD
//   B_UPD : LH=1 H=1 M0=2 M1=1                 -> B_MUL if counter!=n_reg-1 (counter+1), else E_POST
//   E_POST: LS=1 M1=3 M2=2                     -> E_FIN
//   E_FIN : LS=1 M0=3 M2=2                     -> DONE
//   DONE  : pronto=1                           -> IDLE if ack or AUTO_RESTART, else stay
//  Latency inicio-sampled -> pronto: 4 + 4*n_iter cycles (n_iter=0 -> 4; max n=2^CNT_W-1).
//  Counter cleared on IDLE->LOAD; iter = counter; no wrap possible (compare precedes increment).
//  n_iter changes after capture are ignored; inicio high outside IDLE ignored (no queuing).
//  ack outside DONE ignored; ack and inicio together in DONE: go IDLE, inicio not taken that cycle.
//  Reset asserted mid-sequence: immediate return to IDLE, all outputs 0, no pronto.
// CONFIGURATION
//  BLOCO_CTRL_ABORT_EN defined: port abortar exists; abortar=1 in any state except IDLE forces
//   next state IDLE (priority over all transitions, including DONE/ack); counter cleared; no pronto issued.
//  Undefined: port absent; sequence always runs to DONE.
// STRUCTURE
//  Package bloco_controle_pkg: state enum (IDLE..DONE), mux select localparams
//   SEL_A=0 SEL_B=1 SEL_C=2 SEL_D=3, and state-to-output decode function.
//  Sub-module contador_iter (CNT_W): clear, enable, terminal-count compare vs n_reg.
// TESTING
//  n_iter=3, pulse inicio -> pronto after 16 cycles; LX once, LH 6 pulses, LS 5 pulses; iter 0,1,2.
//  n_iter=0 -> LOAD, E_POST, E_FIN, DONE; pronto 4 cycles after start; LH never asserted.
//  AUTO_RESTART=0, ack held low 10 cycles -> pronto stays 1; ack=1 -> IDLE next cycle, pronto=0.
//  n_iter=15 (CNT_W=4), change n_iter mid-run -> 15 loop passes, pronto at cycle 64, iter ends at 14.
//  rst_n low during B_SUM (n_iter=2) -> all outputs 0 immediately; new inicio gives full 12-cycle run.
//  With BLOCO_CTRL_ABORT_EN, abortar=1 in B_ACC -> IDLE next cycle, pronto never 1, ocupado=0.

Source files
------------

// File: rtl/bloco_controle_pkg.sv
// Shared types for the iterative-datapath controller: state encoding, mux select codes
// and the state-to-output decode used by bloco_controle_iter.
package bloco_controle_pkg;

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      B_MUL,
      B_ACC,
      B_SUM,
      B_UPD,
      E_POST,
      E_FIN,
      DONE
   } estado_t;

   localparam logic [1:0] SEL_A = 2'd0;
   localparam logic [1:0] SEL_B = 2'd1;
   localparam logic [1:0] SEL_C = 2'd2;
   localparam logic [1:0] SEL_D = 2'd3;

   typedef struct packed {
      logic [1:0] m0;
      logic [1:0] m1;
      logic [1:0] m2;
      logic       lx;
      logic       lh;
      logic       ls;
      logic       h;
      logic       pronto;
      logic       ocupado;
   } saidas_t;

   function automatic saidas_t decodifica(input estado_t e);
      saidas_t s;
      s = '0;
      case (e)
         LOAD:   begin s.lx = 1'b1; s.h = 1'b1; s.m1 = SEL_B; end
         B_MUL:  begin s.h = 1'b1; s.m1 = SEL_B; end
         B_ACC:  begin s.lh = 1'b1; s.h = 1'b1; s.m1 = SEL_B; end
         B_SUM:  begin
            s.ls = 1'b1; s.h = 1'b1;
            s.m0 = SEL_B; s.m1 = SEL_D; s.m2 = SEL_B;
         end
         B_UPD:  begin s.lh = 1'b1; s.h = 1'b1; s.m0 = SEL_C; s.m1 = SEL_B; end
         E_POST: begin s.ls = 1'b1; s.m1 = SEL_D; s.m2 = SEL_C; end
         E_FIN:  begin s.ls = 1'b1; s.m0 = SEL_D; s.m2 = SEL_C; end
         DONE:   s.pronto = 1'b1;
         default: s = '0;
      endcase
      s.ocupado = (e != IDLE) && (e != DONE);
      return s;
   endfunction

endpackage

// File: rtl/contador_iter.sv
// Loop iteration counter: synchronous clear/increment, flags the last pass against n_reg.
module contador_iter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             limpa,
   input  logic             incr,
   input  logic [CNT_W-1:0] n_reg,
   output logic [CNT_W-1:0] cnt,
   output logic             ultimo
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (limpa) begin
         cnt <= '0;
      end else if (incr) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // n_reg==0 never reaches the loop, so the wrapped n_reg-1 is never consulted
   assign ultimo = (cnt == n_reg - CNT_W'(1));

endmodule

// File: rtl/bloco_controle_iter.sv
// Successor control FSM for the X/H/S iterative datapath: load, N loop passes, epilogue, done/ack.
// Optional abort input enabled by defining BLOCO_CTRL_ABORT_EN.
module bloco_controle_iter #(
   parameter int CNT_W        = 4,
   parameter int SEL_W        = 2,
   parameter int AUTO_RESTART = 0
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef BLOCO_CTRL_ABORT_EN
   input  logic             abortar,
`endif
   input  logic             inicio,
   input  logic [CNT_W-1:0] n_iter,
   input  logic             ack,
   output logic [SEL_W-1:0] M0,
   output logic [SEL_W-1:0] M1,
   output logic [SEL_W-1:0] M2,
   output logic             LX,
   output logic             LH,
   output logic             LS,
   output logic             H,
   output logic             pronto,
   output logic             ocupado,
   output logic [CNT_W-1:0] iter
);

   import bloco_controle_pkg::*;

   estado_t          estado, prox;
   saidas_t          s_prox;
   logic [CNT_W-1:0] n_reg;
   logic [CNT_W-1:0] cnt;
   logic             ultimo;
   logic             inicia;
   logic             aborta;
   logic             incr;

`ifdef BLOCO_CTRL_ABORT_EN
   assign aborta = abortar && (estado != IDLE);
`else
   assign aborta = 1'b0;
`endif

   assign inicia = (estado == IDLE) && inicio;
   assign incr   = (estado == B_UPD) && !ultimo && !aborta;

   always_comb begin
      prox = estado;
      case (estado)
         IDLE:   if (inicio) prox = LOAD;
         LOAD:   prox = (n_reg != '0) ? B_MUL : E_POST;
         B_MUL:  prox = B_ACC;
         B_ACC:  prox = B_SUM;
         B_SUM:  prox = B_UPD;
         B_UPD:  prox = ultimo ? E_POST : B_MUL;
         E_POST: prox = E_FIN;
         E_FIN:  prox = DONE;
         DONE:   if (ack || (AUTO_RESTART != 0)) prox = IDLE;
         default: prox = IDLE;
      endcase
      if (aborta) prox = IDLE;
   end

   assign s_prox = decodifica(prox);

   contador_iter #(.CNT_W(CNT_W)) u_contador (
      .clk    (clk),
      .rst_n  (rst_n),
      .limpa  (inicia || aborta),
      .incr   (incr),
      .n_reg  (n_reg),
      .cnt    (cnt),
      .ultimo (ultimo)
   );

   // Outputs are registered from the next-state decode so they line up with estado
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado  <= IDLE;
         n_reg   <= '0;
         M0      <= '0;
         M1      <= '0;
         M2      <= '0;
         LX      <= 1'b0;
         LH      <= 1'b0;
         LS      <= 1'b0;
         H       <= 1'b0;
         pronto  <= 1'b0;
         ocupado <= 1'b0;
      end else begin
         estado  <= prox;
         if (inicia) n_reg <= n_iter;
         M0      <= SEL_W'(s_prox.m0);
         M1      <= SEL_W'(s_prox.m1);
         M2      <= SEL_W'(s_prox.m2);
         LX      <= s_prox.lx;
         LH      <= s_prox.lh;
         LS      <= s_prox.ls;
         H       <= s_prox.h;
         pronto  <= s_prox.pronto;
         ocupado <= s_prox.ocupado;
      end
   end

   assign iter = cnt;

endmodule

// File: tb/tb_bloco_controle_iter.sv
// Directed bench for bloco_controle_iter (CNT_W=4, SEL_W=2, AUTO_RESTART=0).
// Abort checks are compiled in when BLOCO_CTRL_ABORT_EN is defined.
module tb_bloco_controle_iter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       inicio;
   logic [3:0] n_iter;
   logic       ack;
   logic [1:0] M0, M1, M2;
   logic       LX, LH, LS, H, pronto, ocupado;
   logic [3:0] iter;
`ifdef BLOCO_CTRL_ABORT_EN
   logic       abortar;
`endif

   bloco_controle_iter #(.CNT_W(4), .SEL_W(2), .AUTO_RESTART(0)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
`ifdef BLOCO_CTRL_ABORT_EN
      .abortar (abortar),
`endif
      .inicio  (inicio),
      .n_iter  (n_iter),
      .ack     (ack),
      .M0      (M0),
      .M1      (M1),
      .M2      (M2),
      .LX      (LX),
      .LH      (LH),
      .LS      (LS),
      .H       (H),
      .pronto  (pronto),
      .ocupado (ocupado),
      .iter    (iter)
   );

   always #5 clk = ~clk;

   // {M0,M1,M2,LX,LH,LS,H,pronto,ocupado}
   localparam logic [11:0] O_IDLE  = 12'b000000_000000;
   localparam logic [11:0] O_LOAD  = 12'b000100_100101;
   localparam logic [11:0] O_MUL   = 12'b000100_000101;
   localparam logic [11:0] O_ACC   = 12'b000100_010101;
   localparam logic [11:0] O_SUM   = 12'b011101_001101;
   localparam logic [11:0] O_UPD   = 12'b100100_010101;
   localparam logic [11:0] O_EPOST = 12'b001110_001001;
   localparam logic [11:0] O_EFIN  = 12'b110010_001001;
   localparam logic [11:0] O_DONE  = 12'b000000_000010;

   typedef struct {
      logic        ini;
      logic        ak;
      logic [3:0]  n;
      logic [15:0] exp;
   } vec_t;

   vec_t        tbl [25];
   logic [15:0] bund;
   int          nvec = 0;
   int          nmis = 0;

   assign bund = {M0, M1, M2, LX, LH, LS, H, pronto, ocupado, iter};

   function automatic vec_t mk(input logic i, input logic a, input logic [3:0] n,
                               input logic [11:0] o, input logic [3:0] it);
      vec_t v;
      v.ini = i; v.ak = a; v.n = n; v.exp = {o, it};
      return v;
   endfunction

   task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", nome, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Start a run with n loop passes, then scramble n_iter; measure until pronto.
   task automatic medir(input logic [3:0] n, input int budget, output int lat,
                        output int nlx, output int nlh, output int nls, output int nmul,
                        output logic [15:0] mask);
      inicio = 1'b1; n_iter = n;
      tick();
      inicio = 1'b0; n_iter = ~n;
      lat = 1; nlx = 0; nlh = 0; nls = 0; nmul = 0; mask = '0;
      forever begin
         if (pronto) break;
         nlx += int'(LX); nlh += int'(LH); nls += int'(LS);
         if (H && !LX && !LH && !LS) nmul++;
         if (H && !LX) mask[iter] = 1'b1;
         if (lat >= budget) break;
         tick();
         lat++;
      end
   endtask

   initial begin
      int lat, nlx, nlh, nls, nmul, cnt_p;
      logic [15:0] mask;

      rst_n = 1'b0; inicio = 1'b0; n_iter = '0; ack = 1'b0;
`ifdef BLOCO_CTRL_ABORT_EN
      abortar = 1'b0;
`endif
      #1;
      chk("reset_outputs", 32'(bund), 32'h0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("idle_after_reset", 32'(bund), 32'h0);

      tbl[0]  = mk(1, 0, 4'd1, O_LOAD,  0);
      tbl[1]  = mk(0, 0, 4'd1, O_MUL,   0);
      tbl[2]  = mk(0, 0, 4'd1, O_ACC,   0);
      tbl[3]  = mk(0, 0, 4'd1, O_SUM,   0);
      tbl[4]  = mk(0, 0, 4'd1, O_UPD,   0);
      tbl[5]  = mk(0, 0, 4'd1, O_EPOST, 0);
      tbl[6]  = mk(0, 0, 4'd1, O_EFIN,  0);
      tbl[7]  = mk(0, 0, 4'd1, O_DONE,  0);
      tbl[8]  = mk(1, 1, 4'd1, O_IDLE,  0);
      tbl[9]  = mk(0, 0, 4'd1, O_IDLE,  0);
      tbl[10] = mk(0, 1, 4'd1, O_IDLE,  0);
      tbl[11] = mk(1, 0, 4'd2, O_LOAD,  0);
      tbl[12] = mk(1, 0, 4'd0, O_MUL,   0);
      tbl[13] = mk(0, 0, 4'd0, O_ACC,   0);
      tbl[14] = mk(0, 0, 4'd0, O_SUM,   0);
      tbl[15] = mk(0, 0, 4'd0, O_UPD,   0);
      tbl[16] = mk(0, 0, 4'd0, O_MUL,   1);
      tbl[17] = mk(0, 0, 4'd0, O_ACC,   1);
      tbl[18] = mk(0, 0, 4'd0, O_SUM,   1);
      tbl[19] = mk(0, 0, 4'd0, O_UPD,   1);
      tbl[20] = mk(0, 0, 4'd0, O_EPOST, 1);
      tbl[21] = mk(1, 0, 4'd0, O_EFIN,  1);
      tbl[22] = mk(1, 0, 4'd0, O_DONE,  1);
      tbl[23] = mk(1, 0, 4'd0, O_DONE,  1);
      tbl[24] = mk(0, 1, 4'd0, O_IDLE,  1);

      for (int i = 0; i < 25; i++) begin
         inicio = tbl[i].ini; ack = tbl[i].ak; n_iter = tbl[i].n;
         tick();
         chk($sformatf("vec%0d", i), 32'(bund), 32'(tbl[i].exp));
      end
      inicio = 1'b0; ack = 1'b0;

      // n_iter=3: pulse counts, iter sequence, latency
      medir(4'd3, 200, lat, nlx, nlh, nls, nmul, mask);
      chk("n3_latency", 32'(lat), 32'd16);
      chk("n3_lx_pulses", 32'(nlx), 32'd1);
      chk("n3_lh_pulses", 32'(nlh), 32'd6);
      chk("n3_ls_pulses", 32'(nls), 32'd5);
      chk("n3_iter_seen", 32'(mask), 32'h0007);
      chk("n3_iter_final", 32'(iter), 32'd2);

      // DONE holds while ack stays low
      cnt_p = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         cnt_p += int'(pronto);
      end
      chk("done_hold_10", 32'(cnt_p), 32'd10);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("ack_release", 32'({pronto, ocupado}), 32'd0);

      // n_iter=0 skips the loop
      medir(4'd0, 200, lat, nlx, nlh, nls, nmul, mask);
      chk("n0_latency", 32'(lat), 32'd4);
      chk("n0_lh_never", 32'(nlh), 32'd0);
      chk("n0_ls_pulses", 32'(nls), 32'd2);
      ack = 1'b1; tick(); ack = 1'b0;

      // n_iter=15 with n_iter changed right after capture
      medir(4'd15, 200, lat, nlx, nlh, nls, nmul, mask);
      chk("n15_latency", 32'(lat), 32'd64);
      chk("n15_loop_passes", 32'(nmul), 32'd15);
      chk("n15_iter_final", 32'(iter), 32'd14);
      ack = 1'b1; tick(); ack = 1'b0;

      // Asynchronous reset during B_SUM of an n_iter=2 run
      inicio = 1'b1; n_iter = 4'd2;
      tick();
      inicio = 1'b0;
      tick(); tick(); tick();
      chk("reach_b_sum", 32'(bund), 32'({O_SUM, 4'd0}));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", 32'(bund), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_reset_idle", 32'(bund), 32'h0);
      medir(4'd2, 200, lat, nlx, nlh, nls, nmul, mask);
      chk("rerun_n2_latency", 32'(lat), 32'd12);
      chk("rerun_n2_pronto", 32'(pronto), 32'd1);
      ack = 1'b1; tick(); ack = 1'b0;

`ifdef BLOCO_CTRL_ABORT_EN
      inicio = 1'b1; n_iter = 4'd3;
      tick();
      inicio = 1'b0;
      tick(); tick();
      chk("reach_b_acc", 32'(bund), 32'({O_ACC, 4'd0}));
      abortar = 1'b1;
      tick();
      abortar = 1'b0;
      chk("abort_idle", 32'(bund), 32'h0);
      cnt_p = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         cnt_p += int'(pronto) + int'(ocupado);
      end
      chk("abort_no_pronto", 32'(cnt_p), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation timeout");
   end

endmodule
